apb_mem_slave: RTL and testbench
================================

Name: apb_mem_slave

Overview:
APB4 completer holding a word-addressed SRAM-style register array. It sits directly downstream of the stimc-driven APB emulator and consumes its addr/sel/enable/write/strb/prot/wdata. It returns ready, rdata and slverr, with a configurable number of wait states. Benches use it as a realistic target in place of a tied-off ready/rdata.

Parameters:
ADDR_W, 8, word-address bits; the array holds 2^ADDR_W 32-bit words
WAIT_STATES, 0, wait cycles inserted per access; legal range 0..15

Ports:
apb_clk_i  in  1  APB clock
apb_reset_i  in  1  reset, synchronous to apb_clk_i, active-high
apb_clk_en_i  in  1  clock qualifier; all state updates occur only when high
apb_addr_i  in  32  byte address
apb_sel_i  in  1  PSEL
apb_enable_i  in  1  PENABLE
apb_write_i  in  1  1 = write
apb_strb_i  in  4  byte write strobes
apb_prot_i  in  3  PPROT
apb_wdata_i  in  32  write data
apb_ready_o  out  1  PREADY, registered
apb_rdata_o  out  32  PRDATA, registered
apb_slverr_o  out  1  PSLVERR, registered; valid only while ready is high

Behaviour:
- Interface: one clock, apb_clk_i; reset apb_reset_i is synchronous and active-high. Reset values: ready_o=0, rdata_o=0, slverr_o=0, FSM=IDLE, wait counter=0. Array contents are not reset.
- Cycles with apb_clk_en_i=0 freeze the FSM, counter, outputs and array.
- FSM states:
  - IDLE: on sel=1, enable=0 (setup phase), latch the address decode, load cnt=WAIT_STATES and go to ACCESS. If WAIT_STATES=0, set ready_o=1 on the same edge.
  - ACCESS, ready_o=0: if sel=0, abort to IDLE with no side effects. Otherwise decrement cnt. When cnt==1, set ready_o=1 on the next edge.
  - ACCESS, ready_o=1 and sel&enable=1: this is the completion cycle. Commit the write, clear ready_o and slverr_o, go to IDLE.
- Access phase length is exactly WAIT_STATES+1 cycles.
- Error decode: slverr_o is set together with ready_o when either condition holds:
  - addr[1:0]!=0
  - addr[31:ADDR_W+2]!=0
  On error: no write, rdata_o=0.
- Read: rdata_o is loaded with mem[addr[ADDR_W+1:2]] on the same edge that sets ready_o. rdata_o holds that value until the next read completion.
- Write: on the completion edge, each byte lane i with strb[i]=1 updates from wdata. strb=0 is a legal no-op write. For reads, strb is ignored.
- Back-to-back transfers:
  - A new setup phase is recognised in IDLE on the cycle right after completion.
  - Minimum transfer period is 2+WAIT_STATES cycles.
- Protocol violation: enable=1 seen in IDLE without a preceding setup phase is ignored and the FSM stays IDLE.
- Reset mid-transfer: the FSM goes to IDLE, outputs go to reset values, and a pending write is dropped.
- Address and write controls are sampled in the setup phase. wdata and strb are sampled on the completion edge.

Optional Feature:
APB_MEM_SLAVE_PROT_CHECK_EN
- Defined: accesses to the upper half of the array (addr[ADDR_W+1]=1) with prot[0]=0 (unprivileged) complete with slverr_o=1. Such writes are suppressed and such reads return rdata_o=0. This check is evaluated in the setup phase alongside the address decode.
- Undefined: prot is ignored entirely and the port is left unused.

Test Plan:
- Reset held 3 cycles, then released -> ready_o=0, rdata_o=0, slverr_o=0. The first write to addr 0x04 with wdata 0xDEADBEEF and strb 0xF completes in exactly 1 access cycle when WAIT_STATES=0.
- WAIT_STATES=3: write 0x12345678 to 0x10, then read 0x10 -> each access phase lasts 4 cycles, rdata_o=0x12345678, slverr_o=0.
- Byte strobes: write 0xFFFFFFFF to 0x08, then write 0x00AA00BB with strb 0x5, then read -> 0xFFAAFFBB.
- Error cases:
  - Read at 0x02 -> slverr_o=1, rdata_o=0.
  - With ADDR_W=8, write at 0x400 -> slverr_o=1, and a subsequent read of 0x000 is unchanged.
- Abort and reset:
  - WAIT_STATES=4: drop sel in the 2nd access cycle -> no write occurs and the next transfer completes normally.
  - Assert reset in the 3rd access cycle of a write -> target word is unchanged and ready_o=0 on the next edge.
- Clock enable and prot check:
  - apb_clk_en_i low for 5 cycles mid-access -> ready_o is delayed by exactly 5 cycles.
  - With APB_MEM_SLAVE_PROT_CHECK_EN and ADDR_W=8: prot=3'b000 write to 0x200 -> slverr_o=1. prot=3'b001 to the same address -> OK.

Source files
------------

// File: rtl/apb_mem_slave_if.sv
// APB4 bus bundle between a requester and apb_mem_slave.
interface apb_mem_slave_if;
  logic [31:0] addr;
  logic        sel;
  logic        enable;
  logic        write;
  logic [3:0]  strb;
  logic [2:0]  prot;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        slverr;

  modport master (
    output addr, sel, enable, write, strb, prot, wdata,
    input  ready, rdata, slverr
  );

  modport slave (
    input  addr, sel, enable, write, strb, prot, wdata,
    output ready, rdata, slverr
  );
endinterface

// File: rtl/apb_mem_slave.sv
// APB4 completer over a word-addressed 32-bit array with WAIT_STATES wait cycles per access.
// Optional APB_MEM_SLAVE_PROT_CHECK_EN: unprivileged accesses to the upper half of the array fault.
module apb_mem_slave #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic           apb_clk_i,
  input  logic           apb_reset_i,
  input  logic           apb_clk_en_i,
  apb_mem_slave_if.slave apb
);
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [3:0]  WS    = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              slverr_q, slverr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic              write_q, write_d;
  logic              mem_we;

  logic [31:0]       mem [DEPTH];

  logic              setup;
  logic              addr_err;
  logic [ADDR_W-1:0] addr_idx;
  logic              ld_err;
  logic              ld_write;
  logic [ADDR_W-1:0] ld_idx;
  logic [31:0]       ld_rdata;

  assign setup    = apb.sel & ~apb.enable;
  assign addr_idx = apb.addr[ADDR_W+1:2];

`ifdef APB_MEM_SLAVE_PROT_CHECK_EN
  assign addr_err = (apb.addr[1:0] != 2'b00) ||
                    (apb.addr[31:ADDR_W+2] != '0) ||
                    (apb.addr[ADDR_W+1] && !apb.prot[0]);
`else
  logic unused_prot;
  assign unused_prot = ^apb.prot;
  assign addr_err = (apb.addr[1:0] != 2'b00) ||
                    (apb.addr[31:ADDR_W+2] != '0);
`endif

  // With no wait states ready rises on the setup edge, so the live decode is used there.
  assign ld_idx   = (state_q == IDLE) ? addr_idx  : idx_q;
  assign ld_err   = (state_q == IDLE) ? addr_err  : err_q;
  assign ld_write = (state_q == IDLE) ? apb.write : write_q;
  assign ld_rdata = ld_err ? '0 : (ld_write ? rdata_q : mem[ld_idx]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    slverr_d = slverr_q;
    rdata_d  = rdata_q;
    idx_d    = idx_q;
    err_d    = err_q;
    write_d  = write_q;
    mem_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          idx_d   = addr_idx;
          err_d   = addr_err;
          write_d = apb.write;
          cnt_d   = WS;
          state_d = ACCESS;
          if (WS == 4'd0) begin
            ready_d  = 1'b1;
            slverr_d = ld_err;
            rdata_d  = ld_rdata;
          end
        end
      end
      ACCESS: begin
        if (!apb.sel) begin
          state_d  = IDLE;
          cnt_d    = '0;
          ready_d  = 1'b0;
          slverr_d = 1'b0;
        end else if (!ready_q) begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            ready_d  = 1'b1;
            slverr_d = ld_err;
            rdata_d  = ld_rdata;
          end
        end else if (apb.enable) begin
          mem_we   = write_q & ~err_q;
          ready_d  = 1'b0;
          slverr_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge apb_clk_i) begin
    if (apb_reset_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      slverr_q <= 1'b0;
      rdata_q  <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      write_q  <= 1'b0;
    end else if (apb_clk_en_i) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      slverr_q <= slverr_d;
      rdata_q  <= rdata_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      write_q  <= write_d;
    end
  end

  // Array has no reset; strobes and write data are taken on the completion edge.
  always_ff @(posedge apb_clk_i) begin
    if (!apb_reset_i && apb_clk_en_i && mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (apb.strb[i]) mem[idx_q][8*i +: 8] <= apb.wdata[8*i +: 8];
      end
    end
  end

  assign apb.ready  = ready_q;
  assign apb.rdata  = rdata_q;
  assign apb.slverr = slverr_q;
endmodule

// File: tb/tb_apb_mem_slave.sv
// Self-checking bench for apb_mem_slave: three instances (0, 3 and 4 wait states) against an array model.
module tb_apb_mem_slave;
  localparam int unsigned AW  = 8;
  localparam int unsigned WS0 = 0;
  localparam int unsigned WS1 = 3;
  localparam int unsigned WS2 = 4;
`ifdef APB_MEM_SLAVE_PROT_CHECK_EN
  localparam bit PROT_EN = 1'b1;
`else
  localparam bit PROT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic clk_en;
  always #5 clk = ~clk;

  logic [31:0] addr_v   [3];
  logic        sel_v    [3];
  logic        en_v     [3];
  logic        wr_v     [3];
  logic [3:0]  strb_v   [3];
  logic [2:0]  prot_v   [3];
  logic [31:0] wdata_v  [3];
  logic        ready_v  [3];
  logic [31:0] rdata_v  [3];
  logic        slverr_v [3];

  apb_mem_slave_if bus0 ();
  apb_mem_slave_if bus1 ();
  apb_mem_slave_if bus2 ();

  assign bus0.addr = addr_v[0]; assign bus0.sel = sel_v[0]; assign bus0.enable = en_v[0];
  assign bus0.write = wr_v[0]; assign bus0.strb = strb_v[0]; assign bus0.prot = prot_v[0];
  assign bus0.wdata = wdata_v[0];
  assign ready_v[0] = bus0.ready; assign rdata_v[0] = bus0.rdata; assign slverr_v[0] = bus0.slverr;

  assign bus1.addr = addr_v[1]; assign bus1.sel = sel_v[1]; assign bus1.enable = en_v[1];
  assign bus1.write = wr_v[1]; assign bus1.strb = strb_v[1]; assign bus1.prot = prot_v[1];
  assign bus1.wdata = wdata_v[1];
  assign ready_v[1] = bus1.ready; assign rdata_v[1] = bus1.rdata; assign slverr_v[1] = bus1.slverr;

  assign bus2.addr = addr_v[2]; assign bus2.sel = sel_v[2]; assign bus2.enable = en_v[2];
  assign bus2.write = wr_v[2]; assign bus2.strb = strb_v[2]; assign bus2.prot = prot_v[2];
  assign bus2.wdata = wdata_v[2];
  assign ready_v[2] = bus2.ready; assign rdata_v[2] = bus2.rdata; assign slverr_v[2] = bus2.slverr;

  apb_mem_slave #(.ADDR_W(AW), .WAIT_STATES(WS0)) dut0 (
    .apb_clk_i(clk), .apb_reset_i(rst), .apb_clk_en_i(clk_en), .apb(bus0));
  apb_mem_slave #(.ADDR_W(AW), .WAIT_STATES(WS1)) dut1 (
    .apb_clk_i(clk), .apb_reset_i(rst), .apb_clk_en_i(clk_en), .apb(bus1));
  apb_mem_slave #(.ADDR_W(AW), .WAIT_STATES(WS2)) dut2 (
    .apb_clk_i(clk), .apb_reset_i(rst), .apb_clk_en_i(clk_en), .apb(bus2));

  int checks   = 0;
  int failures = 0;

  // Reference: one word array per instance plus a flag for fully-written words.
  logic [31:0] mdl   [3][256];
  bit          known [3][256];

  // Results of the most recent transfer and the model's expectation for it.
  logic [31:0] r_rd;
  logic        r_se;
  int          r_cyc;
  bit          r_done;
  logic [31:0] e_rd;
  bit          e_err;
  bit          e_known;

  function automatic int ws_of(input int k);
    if (k == 0) return int'(WS0);
    if (k == 1) return int'(WS1);
    return int'(WS2);
  endfunction

  function automatic void model_xfer(input int k, input bit wr, input logic [31:0] a,
                                     input logic [31:0] wd, input logic [3:0] s, input logic [2:0] p);
    int unsigned idx;
    logic [31:0] m;
    idx     = 32'(a[AW+1:2]);
    e_err   = (a[1:0] != 2'b00) || (a[31:AW+2] != '0) || (PROT_EN && a[AW+1] && !p[0]);
    e_rd    = '0;
    e_known = 1'b0;
    if (wr) begin
      if (!e_err) begin
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        mdl[k][idx] = (mdl[k][idx] & ~m) | (wd & m);
        if (s == 4'hF) known[k][idx] = 1'b1;
      end
    end else begin
      e_known = e_err || known[k][idx];
      e_rd    = e_err ? 32'h0 : mdl[k][idx];
    end
  endfunction

  // One transfer on instance k starting at a negedge; returns at the negedge after completion.
  task automatic xfer(input int k, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] s, input logic [2:0] p, input int abort_at = 0,
                      input int reset_at = 0, input int stall_at = 0, input int stall_len = 0);
    r_done = 1'b0; r_cyc = 0; r_rd = '0; r_se = 1'b0;
    sel_v[k] = 1'b1; en_v[k] = 1'b0; wr_v[k] = wr; addr_v[k] = a;
    wdata_v[k] = wd; strb_v[k] = s; prot_v[k] = p;
    @(negedge clk);
    en_v[k] = 1'b1;
    for (int n = 0; n < 64; n++) begin
      r_cyc++;
      if (r_cyc == abort_at) begin
        sel_v[k] = 1'b0; en_v[k] = 1'b0;
        @(negedge clk);
        return;
      end
      if (r_cyc == reset_at) begin
        rst = 1'b1; sel_v[k] = 1'b0; en_v[k] = 1'b0;
        @(negedge clk);
        return;
      end
      clk_en = !(stall_len > 0 && r_cyc >= stall_at && r_cyc < stall_at + stall_len);
      if (clk_en && ready_v[k] === 1'b1) begin
        r_rd = rdata_v[k]; r_se = slverr_v[k]; r_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    clk_en = 1'b1;
    if (r_done) begin
      model_xfer(k, wr, a, wd, s, p);
      @(negedge clk);
    end
    sel_v[k] = 1'b0; en_v[k] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sel_v[k] = 1'b0; en_v[k] = 1'b0; wr_v[k] = 1'b0; addr_v[k] = '0;
      wdata_v[k] = '0; strb_v[k] = '0; prot_v[k] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checks++; if (ready_v[k] !== 1'b0) begin failures++; $display("FAIL reset_ready[%0d]: got %b want 0", k, ready_v[k]); end
      checks++; if (rdata_v[k] !== 32'h0) begin failures++; $display("FAIL reset_rdata[%0d]: got %h want 0", k, rdata_v[k]); end
      checks++; if (slverr_v[k] !== 1'b0) begin failures++; $display("FAIL reset_slverr[%0d]: got %b want 0", k, slverr_v[k]); end
    end
    @(negedge clk);
  endtask

  task automatic test_first_write();
    xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, 4'hF, 3'b000);
    checks++; if (r_done !== 1'b1) begin failures++; $display("FAIL first_write_done: got %b want 1", r_done); end
    checks++; if (r_cyc !== 1) begin failures++; $display("FAIL first_write_cycles: got %0d want 1", r_cyc); end
    checks++; if (r_se !== 1'b0) begin failures++; $display("FAIL first_write_slverr: got %b want 0", r_se); end
    checks++; if (ready_v[0] !== 1'b0) begin failures++; $display("FAIL first_write_ready_clear: got %b want 0", ready_v[0]); end
    xfer(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000);
    checks++; if (r_rd !== 32'hDEADBEEF) begin failures++; $display("FAIL first_read_data: got %h want deadbeef", r_rd); end
    checks++; if (r_cyc !== 1) begin failures++; $display("FAIL first_read_cycles: got %0d want 1", r_cyc); end
  endtask

  task automatic test_wait_states();
    xfer(1, 1'b1, 32'h10, 32'h12345678, 4'hF, 3'b000);
    checks++; if (r_cyc !== 4) begin failures++; $display("FAIL ws3_write_cycles: got %0d want 4", r_cyc); end
    checks++; if (r_se !== 1'b0) begin failures++; $display("FAIL ws3_write_slverr: got %b want 0", r_se); end
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000);
    checks++; if (r_cyc !== 4) begin failures++; $display("FAIL ws3_read_cycles: got %0d want 4", r_cyc); end
    checks++; if (r_rd !== 32'h12345678) begin failures++; $display("FAIL ws3_read_data: got %h want 12345678", r_rd); end
    checks++; if (r_se !== 1'b0) begin failures++; $display("FAIL ws3_read_slverr: got %b want 0", r_se); end
  endtask

  task automatic test_strobes();
    for (int k = 0; k < 3; k++) begin
      xfer(k, 1'b1, 32'h08, 32'hFFFFFFFF, 4'hF, 3'b000);
      xfer(k, 1'b1, 32'h08, 32'h00AA00BB, 4'h5, 3'b000);
      xfer(k, 1'b0, 32'h08, 32'h0, 4'hF, 3'b000);
      checks++; if (r_rd !== 32'hFFAAFFBB) begin failures++; $display("FAIL strobe_merge[%0d]: got %h want ffaaffbb", k, r_rd); end
      xfer(k, 1'b1, 32'h08, 32'h12345678, 4'h0, 3'b000);
      checks++; if (r_done !== 1'b1 || r_se !== 1'b0) begin failures++; $display("FAIL strobe_zero_done[%0d]: got done=%b slverr=%b want 1/0", k, r_done, r_se); end
      xfer(k, 1'b0, 32'h08, 32'h0, 4'h0, 3'b000);
      checks++; if (r_rd !== 32'hFFAAFFBB) begin failures++; $display("FAIL strobe_zero_noop[%0d]: got %h want ffaaffbb", k, r_rd); end
    end
  endtask

  task automatic test_errors();
    for (int k = 0; k < 2; k++) begin
      xfer(k, 1'b1, 32'h000, 32'hCAFEF00D, 4'hF, 3'b000);
      xfer(k, 1'b0, 32'h002, 32'h0, 4'h0, 3'b000);
      checks++; if (r_se !== 1'b1) begin failures++; $display("FAIL misaligned_slverr[%0d]: got %b want 1", k, r_se); end
      checks++; if (r_rd !== 32'h0) begin failures++; $display("FAIL misaligned_rdata[%0d]: got %h want 0", k, r_rd); end
      xfer(k, 1'b1, 32'h400, 32'h11111111, 4'hF, 3'b000);
      checks++; if (r_se !== 1'b1) begin failures++; $display("FAIL range_slverr[%0d]: got %b want 1", k, r_se); end
      xfer(k, 1'b0, 32'h000, 32'h0, 4'h0, 3'b000);
      checks++; if (r_rd !== 32'hCAFEF00D) begin failures++; $display("FAIL range_no_write[%0d]: got %h want cafef00d", k, r_rd); end
      checks++; if (r_se !== 1'b0) begin failures++; $display("FAIL range_read_ok[%0d]: got %b want 0", k, r_se); end
    end
  endtask

  task automatic test_protocol_violation();
    sel_v[1] = 1'b1; en_v[1] = 1'b1; wr_v[1] = 1'b1; addr_v[1] = 32'h10;
    wdata_v[1] = 32'hBAD0BAD0; strb_v[1] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (ready_v[1] !== 1'b0) begin failures++; $display("FAIL no_setup_ready: got %b want 0", ready_v[1]); end
    end
    sel_v[1] = 1'b0; en_v[1] = 1'b0;
    @(negedge clk);
    xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000);
    checks++; if (r_cyc !== 4) begin failures++; $display("FAIL no_setup_next_cycles: got %0d want 4", r_cyc); end
    checks++; if (r_rd !== 32'h12345678) begin failures++; $display("FAIL no_setup_no_write: got %h want 12345678", r_rd); end
  endtask

  task automatic test_abort();
    xfer(2, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF, 3'b000);
    xfer(2, 1'b1, 32'h20, 32'h5A5A5A5A, 4'hF, 3'b000, 2);
    checks++; if (ready_v[2] !== 1'b0) begin failures++; $display("FAIL abort_ready: got %b want 0", ready_v[2]); end
    xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000);
    checks++; if (r_cyc !== 5) begin failures++; $display("FAIL abort_next_cycles: got %0d want 5", r_cyc); end
    checks++; if (r_rd !== 32'hA5A5A5A5) begin failures++; $display("FAIL abort_no_write: got %h want a5a5a5a5", r_rd); end
  endtask

  task automatic test_reset_mid();
    xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000);
    xfer(2, 1'b1, 32'h20, 32'h0F0F0F0F, 4'hF, 3'b000, 0, 3);
    checks++; if (ready_v[2] !== 1'b0) begin failures++; $display("FAIL midreset_ready: got %b want 0", ready_v[2]); end
    checks++; if (rdata_v[2] !== 32'h0) begin failures++; $display("FAIL midreset_rdata: got %h want 0", rdata_v[2]); end
    checks++; if (slverr_v[2] !== 1'b0) begin failures++; $display("FAIL midreset_slverr: got %b want 0", slverr_v[2]); end
    rst = 1'b0;
    @(negedge clk);
    xfer(2, 1'b0, 32'h20, 32'h0, 4'h0, 3'b000);
    checks++; if (r_rd !== 32'hA5A5A5A5) begin failures++; $display("FAIL midreset_dropped: got %h want a5a5a5a5", r_rd); end
    checks++; if (r_cyc !== 5) begin failures++; $display("FAIL midreset_next_cycles: got %0d want 5", r_cyc); end
  endtask

  task automatic test_clk_en();
    xfer(2, 1'b1, 32'h24, 32'h3C3C3C3C, 4'hF, 3'b000);
    xfer(2, 1'b0, 32'h24, 32'h0, 4'h0, 3'b000, 0, 0, 2, 5);
    checks++; if (r_cyc !== 10) begin failures++; $display("FAIL clken_cycles: got %0d want 10", r_cyc); end
    checks++; if (r_rd !== 32'h3C3C3C3C) begin failures++; $display("FAIL clken_data: got %h want 3c3c3c3c", r_rd); end
  endtask

  task automatic test_prot();
    xfer(0, 1'b1, 32'h200, 32'h77777777, 4'hF, 3'b000);
    checks++; if (r_se !== e_err) begin failures++; $display("FAIL prot_user_write: got slverr %b want %b", r_se, e_err); end
    xfer(0, 1'b1, 32'h200, 32'h88888888, 4'hF, 3'b001);
    checks++; if (r_se !== 1'b0) begin failures++; $display("FAIL prot_priv_write: got slverr %b want 0", r_se); end
    xfer(0, 1'b0, 32'h200, 32'h0, 4'h0, 3'b001);
    checks++; if (r_rd !== 32'h88888888) begin failures++; $display("FAIL prot_priv_read: got %h want 88888888", r_rd); end
    xfer(0, 1'b0, 32'h200, 32'h0, 4'h0, 3'b000);
    checks++; if (r_se !== e_err || r_rd !== e_rd) begin failures++; $display("FAIL prot_user_read: got %b/%h want %b/%h", r_se, r_rd, e_err, e_rd); end
  endtask

  task automatic test_back_to_back();
    int unsigned idx;
    logic [31:0] a;
    bit          wr;
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 40; n++) begin
        idx = $urandom_range(15, 0) + ($urandom_range(1, 0) != 0 ? 128 : 0);
        a   = 32'(idx) << 2;
        case ($urandom_range(9, 0))
          0: a[1:0] = 2'($urandom_range(3, 1));
          1: a[12]  = 1'b1;
          default: ;
        endcase
        wr = 1'($urandom_range(1, 0));
        xfer(k, wr, a, $urandom, 4'($urandom), 3'($urandom));
        checks++; if (r_cyc !== ws_of(k) + 1) begin failures++; $display("FAIL b2b_cycles[%0d]: got %0d want %0d", k, r_cyc, ws_of(k) + 1); end
        checks++; if (r_se !== e_err) begin failures++; $display("FAIL b2b_slverr[%0d] addr %h: got %b want %b", k, a, r_se, e_err); end
        if (e_known) begin
          checks++; if (r_rd !== e_rd) begin failures++; $display("FAIL b2b_rdata[%0d] addr %h: got %h want %h", k, a, r_rd, e_rd); end
        end
        checks++; if (ready_v[k] !== 1'b0) begin failures++; $display("FAIL b2b_ready_clear[%0d]: got %b want 0", k, ready_v[k]); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_first_write();
    test_wait_states();
    test_strobes();
    test_errors();
    test_protocol_violation();
    test_abort();
    test_reset_mid();
    test_clk_en();
    test_prot();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
